// File: rtl/imm_pkg.sv
// Package for the immediate encoder.
// Purpose: shared ExtOp codes, immediate field masks and helper functions used by
//          imm_scatter (encode direction) and imm_encoder (optional round-trip check).
// Contents:
//   EXT_I/U/S/B/J  : 3-bit ExtOp codes, same encoding as the core immediate generator
//   imm_fmt_e      : decoded instruction format
//   MASK_*         : instruction bits owned by the immediate for each format
//   decode_fmt     : ExtOp -> format (1xx is J)
//   extract_imm    : core-style immediate extraction from an instruction word
package imm_pkg;

  localparam logic [2:0] EXT_I = 3'b000;
  localparam logic [2:0] EXT_U = 3'b001;
  localparam logic [2:0] EXT_S = 3'b010;
  localparam logic [2:0] EXT_B = 3'b011;
  localparam logic [2:0] EXT_J = 3'b100;

  typedef enum logic [2:0] {
    FMT_I = 3'd0,
    FMT_U = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_J = 3'd4
  } imm_fmt_e;

  // Instruction bits carrying immediate data for each format.
  localparam logic [31:0] MASK_I = 32'hFFF0_0000; // [31:20]
  localparam logic [31:0] MASK_U = 32'hFFFF_F000; // [31:12]
  localparam logic [31:0] MASK_S = 32'hFE00_0F80; // [31:25],[11:7]
  localparam logic [31:0] MASK_B = 32'hFE00_0F80; // [31],[30:25],[11:8],[7]
  localparam logic [31:0] MASK_J = 32'hFFFF_F000; // [31],[30:21],[20],[19:12]

  // Any ExtOp with the top bit set selects J, matching the core decode.
  function automatic imm_fmt_e decode_fmt(input logic [2:0] ext_op);
    imm_fmt_e fmt;
    if (ext_op[2]) begin
      fmt = FMT_J;
    end else begin
      case (ext_op[1:0])
        2'b00:   fmt = FMT_I;
        2'b01:   fmt = FMT_U;
        2'b10:   fmt = FMT_S;
        2'b11:   fmt = FMT_B;
        default: fmt = FMT_I;
      endcase
    end
    return fmt;
  endfunction

  // Same extraction the core immediate generator performs.
  function automatic logic [31:0] extract_imm(input imm_fmt_e fmt, input logic [31:0] i);
    logic [31:0] v;
    case (fmt)
      FMT_I:   v = {{20{i[31]}}, i[31:20]};
      FMT_U:   v = {i[31:12], 12'h000};
      FMT_S:   v = {{20{i[31]}}, i[31:25], i[11:7]};
      FMT_B:   v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      FMT_J:   v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: v = 32'h0000_0000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/imm_scatter.sv
// Combinational immediate scatter.
// Purpose: place a 32-bit immediate into the I/U/S/B/J immediate bits of an RV32I word,
//          taking every other bit from the base instruction, and flag values that the
//          selected format cannot represent. On a range error the immediate bits are 0.
// Ports:
//   ext_op    in  3   format select (000 I, 001 U, 010 S, 011 B, 1xx J)
//   imm       in  32  immediate (two's complement; U carries the full upper value)
//   base      in  32  non-immediate fields; its immediate bits are discarded
//   instr     out 32  encoded instruction
//   range_err out 1   immediate not representable for ext_op
module imm_scatter (
  input  logic [2:0]  ext_op,
  input  logic [31:0] imm,
  input  logic [31:0] base,
  output logic [31:0] instr,
  output logic        range_err
);
  import imm_pkg::*;

  imm_fmt_e    fmt_s;
  logic        ok_s;
  logic [31:0] field_s;
  logic [31:0] mask_s;

  // Range check and field placement per decoded format.
  always_comb begin
    fmt_s   = decode_fmt(ext_op);
    ok_s    = 1'b0;
    field_s = 32'h0000_0000;
    mask_s  = 32'h0000_0000;
    case (fmt_s)
      FMT_I: begin
        ok_s    = (imm[31:12] == {20{imm[11]}});
        field_s = {imm[11:0], 20'h00000};
        mask_s  = MASK_I;
      end
      FMT_U: begin
        ok_s    = (imm[11:0] == 12'h000);
        field_s = {imm[31:12], 12'h000};
        mask_s  = MASK_U;
      end
      FMT_S: begin
        ok_s    = (imm[31:12] == {20{imm[11]}});
        field_s = {imm[11:5], 13'h0000, imm[4:0], 7'h00};
        mask_s  = MASK_S;
      end
      FMT_B: begin
        // Branch offsets are even; bit 0 is not encoded.
        ok_s    = (imm[31:13] == {19{imm[12]}}) && (imm[0] == 1'b0);
        field_s = {imm[12], imm[10:5], 13'h0000, imm[4:1], imm[11], 7'h00};
        mask_s  = MASK_B;
      end
      FMT_J: begin
        ok_s    = (imm[31:21] == {11{imm[20]}}) && (imm[0] == 1'b0);
        field_s = {imm[20], imm[10:1], imm[11], imm[19:12], 12'h000};
        mask_s  = MASK_J;
      end
      default: begin
        ok_s    = 1'b0;
        field_s = 32'h0000_0000;
        mask_s  = 32'h0000_0000;
      end
    endcase
  end

  assign instr     = (base & ~mask_s) | (ok_s ? field_s : 32'h0000_0000);
  assign range_err = ~ok_s;

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: two-stage valid/ready pipeline around imm_scatter.
// Purpose: patch an immediate into a base RV32I instruction (inverse of the core
//          immediate generator), report unrepresentable immediates and count them.
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   InValid/InReady    request handshake (InReady is combinational from OutReady)
//   ExtOp, Imm, BaseInstr  request payload
//   OutValid/OutReady  result handshake
//   Instr, Err         result (held stable while OutValid & !OutReady)
//   ErrCnt             saturating count of error results accepted downstream
//   RtErr              (IMM_ENC_ROUNDTRIP_CHECK_EN only) sticky round-trip mismatch
// Configuration:
//   IMM_ENC_ROUNDTRIP_CHECK_EN : adds the RtErr port and the re-extraction checker in S2.
// Latency is 2 cycles from accept to OutValid without backpressure, 1 word/cycle.
module imm_encoder #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic [2:0]           ExtOp,
  input  logic [31:0]          Imm,
  input  logic [31:0]          BaseInstr,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [31:0]          Instr,
  output logic                 Err,
  output logic [ERR_CNT_W-1:0] ErrCnt
`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
  ,
  output logic                 RtErr
`endif
);
  import imm_pkg::*;

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  logic                 s2_load_s;
  logic                 in_fire_s;
  logic [31:0]          scat_instr_s;
  logic                 scat_err_s;

  logic                 s1_valid_r;
  logic [31:0]          s1_instr_r;
  logic                 s1_err_r;

  logic                 out_valid_r;
  logic [31:0]          instr_r;
  logic                 err_r;
  logic [ERR_CNT_W-1:0] err_cnt_r;

  imm_scatter u_scatter (
    .ext_op    (ExtOp),
    .imm       (Imm),
    .base      (BaseInstr),
    .instr     (scat_instr_s),
    .range_err (scat_err_s)
  );

  // S2 takes a new word whenever it is empty or being drained; S1 moves along with it.
  assign s2_load_s = ~out_valid_r | OutReady;
  assign InReady   = ~s1_valid_r | s2_load_s;
  assign in_fire_s = InValid & InReady;

  // S1 register: encoded word and range flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_instr_r <= 32'h0000_0000;
      s1_err_r   <= 1'b0;
    end else if (in_fire_s) begin
      s1_valid_r <= 1'b1;
      s1_instr_r <= scat_instr_s;
      s1_err_r   <= scat_err_s;
    end else if (s2_load_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // S2 output register; payload only changes when a valid word moves in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      instr_r     <= 32'h0000_0000;
      err_r       <= 1'b0;
    end else if (s2_load_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        instr_r <= s1_instr_r;
        err_r   <= s1_err_r;
      end else begin
        instr_r <= instr_r;
        err_r   <= err_r;
      end
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Saturating count of error words accepted downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_r <= {ERR_CNT_W{1'b0}};
    end else if (out_valid_r && OutReady && err_r && (err_cnt_r != CNT_MAX)) begin
      err_cnt_r <= err_cnt_r + CNT_ONE;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign OutValid = out_valid_r;
  assign Instr    = instr_r;
  assign Err      = err_r;
  assign ErrCnt   = err_cnt_r;

`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
  logic [2:0]  s1_op_r;
  logic [31:0] s1_imm_r;
  logic [2:0]  s2_op_r;
  logic [31:0] s2_imm_r;
  logic        rt_err_r;
  logic [31:0] rt_imm_s;
  logic        rt_mismatch_s;

  // Carry the original request alongside the word so S2 can decode it back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_op_r  <= 3'b000;
      s1_imm_r <= 32'h0000_0000;
      s2_op_r  <= 3'b000;
      s2_imm_r <= 32'h0000_0000;
    end else begin
      if (in_fire_s) begin
        s1_op_r  <= ExtOp;
        s1_imm_r <= Imm;
      end else begin
        s1_op_r  <= s1_op_r;
        s1_imm_r <= s1_imm_r;
      end
      if (s2_load_s && s1_valid_r) begin
        s2_op_r  <= s1_op_r;
        s2_imm_r <= s1_imm_r;
      end else begin
        s2_op_r  <= s2_op_r;
        s2_imm_r <= s2_imm_r;
      end
    end
  end

  // Re-extract with the core decode; only non-error words must round-trip.
  always_comb begin
    rt_imm_s      = extract_imm(decode_fmt(s2_op_r), instr_r);
    rt_mismatch_s = out_valid_r & ~err_r & (rt_imm_s != s2_imm_r);
  end

  // Sticky mismatch flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rt_err_r <= 1'b0;
    end else if (rt_mismatch_s) begin
      rt_err_r <= 1'b1;
    end else begin
      rt_err_r <= rt_err_r;
    end
  end

  assign RtErr = rt_err_r;
`endif

endmodule
